// File: rtl/inv_shift_rows_buf.sv
// AES InvShiftRows stage followed by a small elastic FIFO. Row r of the state is
// cyclically right-shifted by r columns before the state is stored.
module inv_shift_rows_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Byte s[r][c] lives at bits 127-8(4c+r); output s'[r][c] = s[r][(c-r) mod 4].
  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= inv_shift(in_data);
    end
  end

  // Flush takes priority over any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      blk_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      blk_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        blk_cnt <= blk_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_buf.sv
// Directed bench for inv_shift_rows_buf: transform, round trip, backpressure,
// streaming, flush, asynchronous reset and counter wrap.
module tb_inv_shift_rows_buf;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [31:0]  blk_cnt;
  logic         empty;
  logic         full;

  logic         in_ready4;
  logic         out_valid4;
  logic [127:0] out_data4;
  logic [3:0]   blk_cnt4;
  logic         empty4;
  logic         full4;

  int total;
  int bad;

  localparam logic [127:0] VEC_A  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] EXP_A  = 128'h000d0a07_04010e0b_0805020f_0c090603;
  localparam logic [127:0] VEC_B  = 128'h10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] EXP_B  = 128'h101d1a17_14111e1b_1815121f_1c191613;
  localparam logic [127:0] VEC_C  = 128'h20212223_24252627_28292a2b_2c2d2e2f;
  localparam logic [127:0] EXP_C  = 128'h202d2a27_24212e2b_2825222f_2c292623;

  inv_shift_rows_buf #(.DEPTH(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .blk_cnt(blk_cnt), .empty(empty), .full(full)
  );

  // Narrow-counter instance sharing the same stimulus, used for the wrap check.
  inv_shift_rows_buf #(.DEPTH(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .blk_cnt(blk_cnt4), .empty(empty4), .full(full4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward (encryption) ShiftRows: s'[r][c] = s[r][(c+r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] d, input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] x;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #3;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_empty", 128'(empty), 128'(1));
    checkOutput("rst_full", 128'(full), 128'(0));
    checkOutput("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single transform through an empty buffer
    applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
    checkOutput("xf_out_valid", 128'(out_valid), 128'(1));
    checkOutput("xf_out_data", out_data, EXP_A);
    checkOutput("xf_blk_cnt", 128'(blk_cnt), 128'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("xf_drained", 128'(empty), 128'(1));

    // Round trip against the forward transform
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'b1, shift_rows(x), 1'b1, 1'b0);
      checkOutput("rt_data", out_data, x);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("rt_empty", 128'(empty), 128'(1));

    // Streaming: one push and one pop per cycle keeps occupancy at one
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("st_flush_cnt", 128'(blk_cnt), 128'(0));
    for (int i = 0; i < 20; i++) begin
      x = {4{32'(i * 32'h01010101)}};
      applyStimulus(1'b1, shift_rows(x), 1'b1, 1'b0);
      checkOutput("st_valid", 128'(out_valid), 128'(1));
      checkOutput("st_data", out_data, x);
      checkOutput("st_not_full", 128'(full), 128'(0));
    end
    checkOutput("st_blk_cnt", 128'(blk_cnt), 128'(20));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("st_empty", 128'(empty), 128'(1));

    // Backpressure: third push stalls, drain keeps order
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
    checkOutput("bp_full1", 128'(full), 128'(0));
    applyStimulus(1'b1, VEC_B, 1'b0, 1'b0);
    checkOutput("bp_full2", 128'(full), 128'(1));
    checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    applyStimulus(1'b1, VEC_C, 1'b0, 1'b0);
    checkOutput("bp_stall_cnt", 128'(blk_cnt), 128'(2));
    checkOutput("bp_hold_data", out_data, EXP_A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_in_ready_up", 128'(in_ready), 128'(1));
    checkOutput("bp_second", out_data, EXP_B);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("bp_empty", 128'(empty), 128'(1));

    // Flush while full, with in_valid asserted
    applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
    applyStimulus(1'b1, VEC_B, 1'b0, 1'b0);
    applyStimulus(1'b1, VEC_C, 1'b0, 1'b1);
    checkOutput("fl_empty", 128'(empty), 128'(1));
    checkOutput("fl_out_valid", 128'(out_valid), 128'(0));
    checkOutput("fl_blk_cnt", 128'(blk_cnt), 128'(0));

    // Flush overrides a push that would otherwise be accepted
    applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
    applyStimulus(1'b1, VEC_C, 1'b0, 1'b1);
    checkOutput("flp_empty", 128'(empty), 128'(1));
    checkOutput("flp_blk_cnt", 128'(blk_cnt), 128'(0));
    applyStimulus(1'b1, VEC_B, 1'b1, 1'b0);
    checkOutput("flp_next_data", out_data, EXP_B);
    checkOutput("flp_next_cnt", 128'(blk_cnt), 128'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries held
    applyStimulus(1'b1, VEC_A, 1'b0, 1'b0);
    applyStimulus(1'b1, VEC_B, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 128'(out_valid), 128'(0));
    checkOutput("ar_in_ready", 128'(in_ready), 128'(1));
    checkOutput("ar_empty", 128'(empty), 128'(1));
    checkOutput("ar_full", 128'(full), 128'(0));
    checkOutput("ar_blk_cnt", 128'(blk_cnt), 128'(0));
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, VEC_C, 1'b1, 1'b0);
    checkOutput("ar_first_data", out_data, EXP_C);
    checkOutput("ar_first_cnt", 128'(blk_cnt), 128'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Counter wrap on the 4-bit instance
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, VEC_A, 1'b1, 1'b0);
    end
    checkOutput("wrap_cnt4", 128'(blk_cnt4), 128'(1));
    checkOutput("wrap_cnt32", 128'(blk_cnt), 128'(17));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_buf.md
Name: inv_shift_rows_buf

Overview:
- Inverse-cipher InvShiftRows stage for the AES decryption datapath: the decoder-side counterpart of the encryption ShiftRows stage.
- Accepts 128-bit states over a valid/ready handshake and cyclically right-shifts state row r by r columns.
- Buffers results in a small FIFO so it can sit between elastic decrypt-round stages without a combinational ready path.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- CNT_W, 32, width of the processed-block counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear; discards all buffered states.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  stage can accept a state this cycle.
- in_data  input  128  state in; word c = in_data[127-32c -: 32], byte s[r][c] = in_data[127-8(4c+r) -: 8].
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  128  InvShiftRows(state) at FIFO head, same byte packing as in_data.
- blk_cnt  output  CNT_W  count of states accepted since reset or flush.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.

Behaviour:
- Transform (combinational, before write): out s'[r][c] = s[r][(c-r) mod 4].
  - Row 0 is unchanged.
  - Row 1: column c takes column c-1.
  - Row 2: swap columns across 2.
  - Row 3: column c takes column c+1.
  - The transform is the exact inverse of the encryption ShiftRows.
- Storage: DEPTH x 128 register array.
  - Write pointer and read pointer are log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count is log2(DEPTH)+1 bits.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = !full. It is a function of registered state only; no combinational path from out_ready.
- out_valid = !empty. out_data = mem[rd_ptr], driven directly from registered storage.
- Latency: a state pushed in cycle N is visible on out_data/out_valid in cycle N+1 when the FIFO was empty. There is no bypass.
- Throughput: one state per cycle sustained when out_ready is held high.
- Simultaneous push and pop (not full, not empty): both pointers advance and the count is unchanged.
- Full: in_ready=0, so no push is possible. A pop in that cycle raises in_ready in the next cycle.
- Empty: a pop is impossible since out_valid=0. out_data holds the stale head and is don't-care.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- blk_cnt increments on every push and wraps from 2^CNT_W-1 to 0.
- flush (synchronous):
  - Sets pointers, count and blk_cnt to 0.
  - Overrides a push or pop in the same cycle; the incoming state is dropped.
  - in_ready stays at its registered value during the flush cycle.
- Reset (asynchronous, rst_n low):
  - Pointers, count and blk_cnt go to 0 immediately, so out_valid=0, in_ready=1, empty=1, full=0.
  - Memory contents are not reset; out_data is don't-care while empty.
  - Reset asserted mid-transfer discards all entries. On deassertion the first accepted state starts from wr_ptr=0.
- No state machine beyond the pointers and count.

Test Plan:
- Transform check: push 00010203_04050607_08090a0b_0c0d0e0f into the empty buffer with out_ready=1 → the next cycle gives out_valid=1 and out_data=000d0a07_04010e0b_0805020f_0c090603; blk_cnt=1.
- Round trip: feed the encryption ShiftRows output of random states through this block → out_data equals the original state for 1000 random vectors.
- Backpressure/full: out_ready=0, push 3 states with DEPTH=2 → the third push is stalled with in_ready=0 and full=1 after 2 pushes. Raising out_ready then drains the states in order with no loss and no duplication.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles → 20 outputs on consecutive cycles starting 1 cycle after the first push; count stays 1; blk_cnt=20.
- Flush and reset: with 2 entries held, assert flush together with in_valid=1 → the next cycle gives empty=1, blk_cnt=0, and the pushed state is never output. Repeat with rst_n pulsed low asynchronously mid-cycle → out_valid drops without waiting for a clock edge.
- Counter wrap: CNT_W=4, push 17 states → blk_cnt reads 1.
